train_sequencer: RTL
====================

# train_sequencer

Sequences one train passage through the approach section. It measures the S1→S2 transit time in milliseconds and runs a sequential prediction of the time remaining until the gate must close. It then counts that time down and holds `gate_close` until the train clears exit sensor S3. It sits between the track sensors and the crossing-gate actuator and replaces free-running combinational prediction with a start/done-sequenced datapath.

## Interface
- `TICK_DIV`, 50000: clk cycles per 1 ms tick (50 MHz clock).
- `DIS_S1_S2`, 41: distance S1→S2, in metres; must be nonzero.
- `DIS_S2`, 666: distance S2→gate, in metres; must be below 1024.
- `LEAD_MS`, 30000: safety lead subtracted from the predicted arrival, in ms.
- `TIMEOUT_MS`, 524287: maximum S1→S2 time before the measurement is abandoned.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s1`, `s2`, `s3`  in  1 each  sensor levels, already synchronised to `clk`; active high.
- `gate_close`  out  1  gate actuator command.
- `busy`  out  1  high in any state except IDLE.
- `t_meas`  out  19  latched S1→S2 time in ms.
- `t_pred`  out  19  latched countdown load value in ms.
- `timeout`  out  1  one-cycle pulse when a measurement is abandoned.

## Operation
- Rising-edge detectors run on `s1`, `s2` and `s3`; the previous-value registers reset to 0. A sensor that is high at reset release therefore counts as an edge.
- Ms prescaler counts 0..TICK_DIV-1 and emits `tick` on wrap. The prescaler clears on entry to MEASURE and on entry to COUNTDOWN.
- **IDLE:** `s1` edge → MEASURE and clear the ms counter. `s2` and `s3` edges are ignored.
- **MEASURE:** the ms counter increments on each `tick`.
  - `s2` edge → latch the counter into `t_meas` and go to CALC.
  - Counter reaching TIMEOUT_MS → pulse `timeout` and go to IDLE.
  - `s1` edges are ignored.
- **CALC:**
  - Pulse `div_start` for 1 cycle, with dividend = DIS_S2 × `t_meas` and divisor = DIS_S1_S2.
  - On `div_done`, compute quotient − LEAD_MS as a signed value and clamp it to [0, 2^19−1].
  - Write the clamped value to `t_pred` and to the countdown register.
  - Next state is CLOSED if the value is 0, otherwise COUNTDOWN.
- **COUNTDOWN:** decrement on each `tick`. When the value reaches 0, go to CLOSED in the same cycle.
- **CLOSED:** `gate_close` = 1. `s3` edge → IDLE, which drops `gate_close` the following cycle.
- Sensor edges not listed for a state are ignored. There is no queuing of a second train.
- An `s1` edge and an `s2` edge in the same IDLE cycle: `s1` is taken and `s2` is lost.
- An `s2` edge in the first MEASURE cycle gives `t_meas` = 0, so `t_pred` = 0 and the block goes to CLOSED.
- `t_meas` and `t_pred` hold their values until the next overwrite.

## Timing
- Reset values: state = IDLE; `gate_close`, `busy`, `timeout`, `t_meas`, `t_pred` all 0; counters 0; divider idle.
- Registered outputs change 1 cycle after the causing edge or tick.
- CALC latency is DIV_W + 2 cycles from CALC entry to leaving CALC:
  - DIV_W = 19 + 10 = 29 dividend bits, one restoring iteration per cycle.
  - `div_done` is a 1-cycle pulse with the quotient valid in the same cycle.
- Gate closes `t_pred` ticks after CALC exit, with jitter below 1 ms. The prescaler is cleared on COUNTDOWN entry.
- The ms counter saturates and never wraps. Quotient overflow beyond 19 bits saturates.
- `rst` mid-operation returns to IDLE next cycle, aborts the divider and drops `gate_close`.

## Structure
- Shared package `train_pkg`:
  - state enum {IDLE, MEASURE, CALC, COUNTDOWN, CLOSED};
  - `T_W` = 19;
  - default distance and lead constants.
- Sub-module `seq_divider`:
  - unsigned restoring divider, parameterised widths;
  - start/done handshake; `start` ignored while busy;
  - synchronous reset on `rst`.
- The top level holds the FSM, edge detectors, prescaler and ms counter/countdown.

## Test plan
Use TICK_DIV = 4 and TIMEOUT_MS = 100000 unless a line states otherwise.
- Nominal: `s1`, then `s2` 4100 ms later → `t_meas` = 4100 and `t_pred` = 36600 (666·4100/41 = 66600, minus 30000). `gate_close` rises 36600 ticks ±1 tick after CALC exit. An `s3` edge then returns the block to IDLE and drops `gate_close`.
- Fast train: `t_meas` = 1000 → quotient 16243, clamped to `t_pred` = 0. CLOSED entered directly from CALC with no COUNTDOWN cycles.
- Overflow: with TIMEOUT_MS = 524287, `t_meas` = 41000 → `t_pred` saturates to 524287.
- Timeout: TIMEOUT_MS = 100 and no `s2` → `timeout` pulses once at count 100. Block returns to IDLE with `gate_close` = 0.
- Spurious edges: `s2` in IDLE, `s1` in MEASURE and `s3` in COUNTDOWN → no state change and no output change.
- Reset mid-COUNTDOWN and again mid-CALC: 1 cycle later all outputs are 0 and the state is IDLE. The next `s1` edge starts a clean measurement.

Source files
------------

// File: rtl/train_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : train_pkg
// Brief    : Shared widths, default constants, state encoding and the
//            prediction clamp for the train sequencer.
// Revision : 1.0
// ============================================================================
package train_pkg;

  localparam int T_W    = 19;
  localparam int DIST_W = 10;
  localparam int DIV_W  = T_W + DIST_W;

  localparam int c_tick_div   = 50000;
  localparam int c_dis_s1_s2  = 41;
  localparam int c_dis_s2     = 666;
  localparam int c_lead_ms    = 30000;
  localparam int c_timeout_ms = 524287;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MEASURE   = 3'd1,
    CALC      = 3'd2,
    COUNTDOWN = 3'd3,
    CLOSED    = 3'd4
  } state_t;

  // Signed (quotient - lead), floored at 0 and saturated at the T_W maximum.
  function automatic logic [T_W-1:0] clamp_pred(input logic [DIV_W-1:0] quo,
                                                 input logic [DIV_W:0]   lead);
    logic [DIV_W+1:0] diff;
    logic [T_W-1:0]   res;
    diff = {2'b00, quo} - {1'b0, lead};
    if (diff[DIV_W+1])
      res = '0;
    else if (|diff[DIV_W:T_W])
      res = '1;
    else
      res = diff[T_W-1:0];
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/train_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : train_sequencer_if
// Brief     : Sensor inputs and gate/status outputs of the train sequencer.
// Revision  : 1.0
// ============================================================================
interface train_sequencer_if;
  import train_pkg::*;

  logic           s1;
  logic           s2;
  logic           s3;
  logic           gate_close;
  logic           busy;
  logic [T_W-1:0] t_meas;
  logic [T_W-1:0] t_pred;
  logic           timeout;

  modport master (
    output s1, s2, s3,
    input  gate_close, busy, t_meas, t_pred, timeout
  );

  modport slave (
    input  s1, s2, s3,
    output gate_close, busy, t_meas, t_pred, timeout
  );
endinterface
`default_nettype wire

// File: rtl/train_sequencer_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Unsigned restoring divider, one quotient bit per cycle,
//            start/done handshake with a single-cycle done pulse.
// Revision : 1.0
// ============================================================================
module seq_divider #(
  parameter int DVD_W = 29,
  parameter int DVS_W = 10
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_start,
  input  wire logic [DVD_W-1:0] i_dividend,
  input  wire logic [DVS_W-1:0] i_divisor,
  output logic                  o_done,
  output logic      [DVD_W-1:0] o_quotient
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] r_rem;
  logic [DVS_W-1:0] r_dvs;
  logic [DVD_W-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [DVS_W:0]   w_shift;
  logic [DVS_W:0]   w_diff;
  logic             w_ge;

  // Remainder stays below the divisor, so the shifted value fits DVS_W+1 bits.
  assign w_shift = {r_rem, r_quo[DVD_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_rem  <= '0;
          r_dvs  <= i_divisor;
          r_quo  <= i_dividend;
          r_cnt  <= CNT_W'(DVD_W);
          r_busy <= 1'b1;
        end
      end else begin
        r_rem <= w_ge ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];
        r_quo <= {r_quo[DVD_W-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/train_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : train_sequencer
// Brief    : Measures S1->S2 transit time, predicts gate-close delay with a
//            sequential divider, counts it down and holds the gate until S3.
// Revision : 1.0
// ============================================================================
module train_sequencer
  import train_pkg::*;
#(
  parameter int TICK_DIV   = c_tick_div,
  parameter int DIS_S1_S2  = c_dis_s1_s2,
  parameter int DIS_S2     = c_dis_s2,
  parameter int LEAD_MS    = c_lead_ms,
  parameter int TIMEOUT_MS = c_timeout_ms
) (
  input wire logic          clk,
  input wire logic          rst,
  train_sequencer_if.slave  bus
);

  localparam int                PRE_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  c_pre_last  = PRE_W'(TICK_DIV - 1);
  localparam logic [T_W-1:0]    c_timeout   = T_W'(TIMEOUT_MS);
  localparam logic [DIV_W:0]    c_lead      = (DIV_W + 1)'(LEAD_MS);
  localparam logic [DIST_W-1:0] c_dist_s1s2 = DIST_W'(DIS_S1_S2);
  localparam logic [DIST_W-1:0] c_dist_s2   = DIST_W'(DIS_S2);

  state_t           r_state;
  logic             r_s1_q, r_s2_q, r_s3_q;
  logic [PRE_W-1:0] r_pre;
  logic [T_W-1:0]   r_cnt;
  logic [T_W-1:0]   r_t_meas;
  logic [T_W-1:0]   r_t_pred;
  logic             r_gate;
  logic             r_busy;
  logic             r_timeout;
  logic             r_div_start;

  logic             w_s1_rise, w_s2_rise, w_s3_rise;
  logic             w_tick;
  logic [DIV_W-1:0] w_dividend;
  logic [DIV_W-1:0] w_quo;
  logic             w_div_done;
  logic [T_W-1:0]   w_pred;

  assign w_s1_rise  = bus.s1 & ~r_s1_q;
  assign w_s2_rise  = bus.s2 & ~r_s2_q;
  assign w_s3_rise  = bus.s3 & ~r_s3_q;
  assign w_tick     = (r_pre == c_pre_last);
  assign w_dividend = DIV_W'(c_dist_s2) * DIV_W'(r_t_meas);
  assign w_pred     = clamp_pred(w_quo, c_lead);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_q <= 1'b0;
      r_s2_q <= 1'b0;
      r_s3_q <= 1'b0;
    end else begin
      r_s1_q <= bus.s1;
      r_s2_q <= bus.s2;
      r_s3_q <= bus.s3;
    end
  end

  seq_divider #(
    .DVD_W (DIV_W),
    .DVS_W (DIST_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (c_dist_s1s2),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pre       <= '0;
      r_cnt       <= '0;
      r_t_meas    <= '0;
      r_t_pred    <= '0;
      r_gate      <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_div_start <= 1'b0;
    end else begin
      r_timeout   <= 1'b0;
      r_div_start <= 1'b0;
      r_pre       <= w_tick ? '0 : r_pre + 1'b1;
      case (r_state)
        IDLE: begin
          if (w_s1_rise) begin
            r_state <= MEASURE;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_pre   <= '0;
          end
        end
        MEASURE: begin
          if (w_s2_rise) begin
            r_t_meas    <= r_cnt;
            r_state     <= CALC;
            r_div_start <= 1'b1;
          end else if (r_cnt == c_timeout) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end else if (w_tick && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CALC: begin
          if (w_div_done) begin
            r_t_pred <= w_pred;
            r_cnt    <= w_pred;
            if (w_pred == '0) begin
              r_state <= CLOSED;
              r_gate  <= 1'b1;
            end else begin
              r_state <= COUNTDOWN;
              r_pre   <= '0;
            end
          end
        end
        COUNTDOWN: begin
          if (w_tick) begin
            if (r_cnt <= T_W'(1)) begin
              r_cnt   <= '0;
              r_state <= CLOSED;
              r_gate  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        CLOSED: begin
          if (w_s3_rise) begin
            r_state <= IDLE;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gate  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_close = r_gate;
  assign bus.busy       = r_busy;
  assign bus.t_meas     = r_t_meas;
  assign bus.t_pred     = r_t_pred;
  assign bus.timeout    = r_timeout;

endmodule
`default_nettype wire
